// File: rtl/jump_trace_buffer.sv
// Watches the committed fetch stream for non-sequential PC transitions and
// queues {from_pc, to_pc, from_instr} records in a first-word-fall-through FIFO.
module jump_trace_buffer #(
   parameter int PC_WIDTH    = 12,
   parameter int INSTR_WIDTH = 32,
   parameter int DEPTH       = 16,
   parameter int CNT_WIDTH   = 16,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   pc_valid,
   input  logic [PC_WIDTH-1:0]    pc,
   input  logic [INSTR_WIDTH-1:0] instr,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [PC_WIDTH-1:0]    rd_from,
   output logic [PC_WIDTH-1:0]    rd_to,
   output logic [INSTR_WIDTH-1:0] rd_instr,
   output logic [AW:0]            count,
   output logic                   overflow,
   output logic [CNT_WIDTH-1:0]   jump_total
);

   typedef enum logic {NO_PREV, TRACK} state_t;

   state_t                 state, state_next;
   logic [PC_WIDTH-1:0]    prev_pc;
   logic [INSTR_WIDTH-1:0] prev_instr;
   logic [PC_WIDTH-1:0]    seq_pc;
   logic                   active;
   logic                   latch;
   logic                   jump_evt;
   logic                   pop;
   logic                   push;
   logic                   drop;

   logic [PC_WIDTH-1:0]    mem_from  [DEPTH];
   logic [PC_WIDTH-1:0]    mem_to    [DEPTH];
   logic [INSTR_WIDTH-1:0] mem_instr [DEPTH];
   logic [AW-1:0]          rd_ptr, wr_ptr;

   // A cycle under reset or clear must neither track nor touch the FIFO.
   assign active = reset && !clear;
   assign seq_pc = prev_pc + PC_WIDTH'(1);

   always_comb begin
      state_next = state;
      latch      = 1'b0;
      jump_evt   = 1'b0;
      if (active && pc_valid) begin
         latch      = 1'b1;
         state_next = TRACK;
         if (state == TRACK && pc != seq_pc) begin
            jump_evt = 1'b1;
         end
      end
   end

   assign rd_valid = (count != '0);
   assign pop      = active && rd_valid && rd_ready;
   assign push     = jump_evt && ((count < (AW+1)'(DEPTH)) || pop);
   assign drop     = jump_evt && !push;

   assign rd_from  = rd_valid ? mem_from[rd_ptr]  : '0;
   assign rd_to    = rd_valid ? mem_to[rd_ptr]    : '0;
   assign rd_instr = rd_valid ? mem_instr[rd_ptr] : '0;

   always_ff @(posedge clock) begin
      if (!reset || clear) begin
         state      <= NO_PREV;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         jump_total <= '0;
      end else begin
         state <= state_next;
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (push && !pop) begin
            count <= count + (AW+1)'(1);
         end else if (pop && !push) begin
            count <= count - (AW+1)'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         if (jump_evt && jump_total != '1) begin
            jump_total <= jump_total + CNT_WIDTH'(1);
         end
      end
   end

   // Data storage carries no reset; validity is owned by state and count.
   always_ff @(posedge clock) begin
      if (latch) begin
         prev_pc    <= pc;
         prev_instr <= instr;
      end
      if (push) begin
         mem_from[wr_ptr]  <= prev_pc;
         mem_to[wr_ptr]    <= pc;
         mem_instr[wr_ptr] <= prev_instr;
      end
   end

endmodule

// File: tb/tb_jump_trace_buffer.sv
// Scoreboard bench for jump_trace_buffer: a reference tracker pushes expected
// records when jumps are driven; records are compared as the DUT pops them.
module tb_jump_trace_buffer;

   localparam int PW = 12;
   localparam int IW = 32;
   localparam int D  = 16;
   localparam int CW = 16;

   typedef struct packed {
      logic [PW-1:0] from;
      logic [PW-1:0] to;
      logic [IW-1:0] ins;
   } rec_t;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          clear = 1'b0;
   logic          pc_valid = 1'b0;
   logic [PW-1:0] pc = '0;
   logic [IW-1:0] instr = '0;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic [PW-1:0] rd_from;
   logic [PW-1:0] rd_to;
   logic [IW-1:0] rd_instr;
   logic [4:0]    count;
   logic          overflow;
   logic [CW-1:0] jump_total;

   int checks = 0;
   int errors = 0;

   rec_t          sb[$];
   logic          m_track = 1'b0;
   logic [PW-1:0] m_prev = '0;
   logic [IW-1:0] m_prev_ins = '0;
   logic          m_ovf = 1'b0;
   logic [CW-1:0] m_total = '0;

   jump_trace_buffer #(.PC_WIDTH(PW), .INSTR_WIDTH(IW), .DEPTH(D), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset), .clear(clear), .pc_valid(pc_valid), .pc(pc),
      .instr(instr), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_from(rd_from),
      .rd_to(rd_to), .rd_instr(rd_instr), .count(count), .overflow(overflow),
      .jump_total(jump_total)
   );

   always #5 clock = ~clock;

   function automatic logic [IW-1:0] ins_of(input logic [PW-1:0] p);
      return 32'hA500_0000 ^ {4'h0, p, 4'h0, p};
   endfunction

   // One clock: drive inputs, advance the reference model, pop-compare, wait past the edge.
   task automatic step(input logic rst_n, input logic clr, input logic pv,
                       input logic [PW-1:0] p, input logic rdy);
      rec_t          exp;
      logic          pop_m;
      logic [PW-1:0] nxt;
      reset = rst_n; clear = clr; pc_valid = pv; pc = p; instr = ins_of(p); rd_ready = rdy;
      #1;
      if (!rst_n || clr) begin
         sb.delete();
         m_track = 1'b0; m_ovf = 1'b0; m_total = '0;
      end else begin
         pop_m = rdy && (sb.size() != 0);
         if (pop_m) begin
            exp = sb.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_from !== exp.from || rd_to !== exp.to || rd_instr !== exp.ins) begin
               errors++;
               $display("FAIL pop_record: got v=%0b from=%0d to=%0d ins=%h, expected v=1 from=%0d to=%0d ins=%h",
                        rd_valid, rd_from, rd_to, rd_instr, exp.from, exp.to, exp.ins);
            end
         end
         nxt = m_prev + 12'd1;
         if (pv && m_track && p != nxt) begin
            if (m_total != '1) m_total++;
            if (sb.size() < D) sb.push_back('{from: m_prev, to: p, ins: m_prev_ins});
            else m_ovf = 1'b1;
         end
         if (pv) begin
            m_track = 1'b1; m_prev = p; m_prev_ins = ins_of(p);
         end
      end
      @(posedge clock); #1;
      pc_valid = 1'b0; rd_ready = 1'b0; clear = 1'b0; reset = 1'b1;
   endtask

   task automatic drain();
      int n;
      n = sb.size();
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic test_reset();
      step(1'b0, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 12'd7, 1'b1);
      checks++;
      if (rd_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b0 || jump_total !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: v=%0b cnt=%0d ovf=%0b tot=%0d, expected all 0", rd_valid, count, overflow, jump_total);
      end
      checks++;
      if (rd_from !== 12'd0 || rd_to !== 12'd0 || rd_instr !== 32'd0) begin
         errors++;
         $display("FAIL reset_rd_zero: from=%0d to=%0d ins=%h, expected 0", rd_from, rd_to, rd_instr);
      end
   endtask

   task automatic test_sequential();
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 12'(i), 1'b0);
      checks++;
      if (rd_valid !== 1'b0 || count !== 5'd0 || jump_total !== 16'd0) begin
         errors++;
         $display("FAIL seq_no_event: v=%0b cnt=%0d tot=%0d, expected 0 0 0", rd_valid, count, jump_total);
      end
   endtask

   task automatic test_single_jump();
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd5, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd6, 1'b0);
      checks++;
      if (rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL jump_not_early: rd_valid=%0b, expected 0", rd_valid);
      end
      step(1'b1, 1'b0, 1'b1, 12'd20, 1'b0);
      checks++;
      if (rd_valid !== 1'b1 || count !== 5'd1 || jump_total !== 16'd1) begin
         errors++;
         $display("FAIL jump_visible: v=%0b cnt=%0d tot=%0d, expected 1 1 1", rd_valid, count, jump_total);
      end
      checks++;
      if (rd_from !== 12'd6 || rd_to !== 12'd20 || rd_instr !== ins_of(12'd6)) begin
         errors++;
         $display("FAIL jump_head: from=%0d to=%0d ins=%h, expected 6 20 %h", rd_from, rd_to, rd_instr, ins_of(12'd6));
      end
      step(1'b1, 1'b0, 1'b1, 12'd21, 1'b0);
      checks++;
      if (count !== 5'd1 || jump_total !== 16'd1) begin
         errors++;
         $display("FAIL jump_seq_after: cnt=%0d tot=%0d, expected 1 1", count, jump_total);
      end
      drain();
   endtask

   task automatic test_wrap();
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd4094, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd4095, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd1, 1'b0);
      checks++;
      if (count !== 5'd0 || jump_total !== 16'd0) begin
         errors++;
         $display("FAIL wrap_sequential: cnt=%0d tot=%0d, expected 0 0", count, jump_total);
      end
      step(1'b1, 1'b0, 1'b1, 12'd1, 1'b0);
      checks++;
      if (count !== 5'd1 || rd_from !== 12'd1 || rd_to !== 12'd1) begin
         errors++;
         $display("FAIL self_loop: cnt=%0d from=%0d to=%0d, expected 1 1 1", count, rd_from, rd_to);
      end
      drain();
   endtask

   task automatic test_overflow();
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd100, 1'b0);
      for (int k = 1; k <= 17; k++) step(1'b1, 1'b0, 1'b1, 12'(100 + 3 * k), 1'b0);
      checks++;
      if (count !== 5'd16 || overflow !== 1'b1 || jump_total !== 16'd17) begin
         errors++;
         $display("FAIL overflow_state: cnt=%0d ovf=%0b tot=%0d, expected 16 1 17", count, overflow, jump_total);
      end
      drain();
      checks++;
      if (rd_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_drained: v=%0b cnt=%0d ovf=%0b, expected 0 0 1", rd_valid, count, overflow);
      end
   endtask

   task automatic test_full_push_pop();
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd200, 1'b0);
      for (int k = 1; k <= 16; k++) step(1'b1, 1'b0, 1'b1, 12'(200 + 5 * k), 1'b0);
      checks++;
      if (count !== 5'd16 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL full_state: cnt=%0d ovf=%0b, expected 16 0", count, overflow);
      end
      step(1'b1, 1'b0, 1'b1, 12'd900, 1'b1);
      checks++;
      if (count !== 5'd16 || overflow !== 1'b0 || jump_total !== 16'd17) begin
         errors++;
         $display("FAIL full_push_pop: cnt=%0d ovf=%0b tot=%0d, expected 16 0 17", count, overflow, jump_total);
      end
      drain();
      checks++;
      if (rd_valid !== 1'b0 || count !== 5'd0) begin
         errors++;
         $display("FAIL full_drained: v=%0b cnt=%0d, expected 0 0", rd_valid, count);
      end
   endtask

   task automatic test_back_to_back();
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd10, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd20, 1'b1);
      checks++;
      if (count !== 5'd1 || rd_from !== 12'd10 || rd_to !== 12'd20) begin
         errors++;
         $display("FAIL b2b_head: cnt=%0d from=%0d to=%0d, expected 1 10 20", count, rd_from, rd_to);
      end
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (rd_valid !== 1'b0 || rd_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_empty: v=%0b, expected 0", rd_valid);
      end
      step(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if (count !== 5'd0) begin
         errors++;
         $display("FAIL ready_when_empty: cnt=%0d, expected 0", count);
      end
   endtask

   task automatic test_flush(input logic use_reset);
      step(1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b1, 1'b0, 1'b1, 12'd300, 1'b0);
      for (int k = 1; k <= 3; k++) step(1'b1, 1'b0, 1'b1, 12'(300 + 7 * k), 1'b0);
      checks++;
      if (count !== 5'd3) begin
         errors++;
         $display("FAIL flush_setup: cnt=%0d, expected 3", count);
      end
      if (use_reset) step(1'b0, 1'b0, 1'b1, 12'd400, 1'b1);
      else           step(1'b1, 1'b1, 1'b1, 12'd400, 1'b1);
      checks++;
      if (count !== 5'd0 || overflow !== 1'b0 || jump_total !== 16'd0 || rd_valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_state(rst=%0b): cnt=%0d ovf=%0b tot=%0d v=%0b, expected 0 0 0 0",
                  use_reset, count, overflow, jump_total, rd_valid);
      end
      step(1'b1, 1'b0, 1'b1, 12'd500, 1'b0);
      checks++;
      if (count !== 5'd0 || jump_total !== 16'd0) begin
         errors++;
         $display("FAIL flush_no_prev(rst=%0b): cnt=%0d tot=%0d, expected 0 0", use_reset, count, jump_total);
      end
      step(1'b1, 1'b0, 1'b1, 12'd700, 1'b0);
      checks++;
      if (count !== 5'd1 || rd_from !== 12'd500 || rd_to !== 12'd700) begin
         errors++;
         $display("FAIL flush_resume(rst=%0b): cnt=%0d from=%0d to=%0d, expected 1 500 700",
                  use_reset, count, rd_from, rd_to);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_single_jump();
      test_wrap();
      test_overflow();
      test_full_push_pop();
      test_back_to_back();
      test_flush(1'b0);
      test_flush(1'b1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
